audio_pwm_mixer: RTL

Parametrised successor to the single-channel PWM audio output. It accepts CHANNELS streams of unsigned offset-binary samples through valid/ready handshakes and consumes one sample per channel on each sample-rate tick. Each sample is attenuated per channel, and the results are summed with saturation. The mix drives a glitch-free PWM output whose duty changes only at PWM period boundaries. It sits between the sample FIFOs (music, effects) and the board's `aud_pwm_out` tri-state driver.

---
 rtl/audio_pwm_mixer.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/audio_pwm_mixer.sv
// audio_pwm_mixer: multi-channel sample mixer feeding a glitch-free PWM DAC.
// Each channel has a one-deep holding register filled over valid/ready and
// drained on every sample tick. Drained samples are attenuated, muted, summed
// with saturation, and the mix sets the PWM duty at the next period boundary.
//
// Build option: define AUDIO_PWM_HOLD_EN to replay the last consumed sample of
// a channel that underruns. Without it, an underrunning channel plays silence
// (midscale) and the last-sample registers are not built.
module audio_pwm_mixer #(
  parameter int SAMPLE_W   = 8,
  parameter int CHANNELS   = 2,
  parameter int SAMPLE_DIV = 4096
) (
  input  logic                         clk_100mhz,
  input  logic                         rst_n_in,
  input  logic                         enable_in,
  input  logic [CHANNELS*SAMPLE_W-1:0] sample_in,
  input  logic [CHANNELS-1:0]          valid_in,
  output logic [CHANNELS-1:0]          ready_out,
  input  logic [CHANNELS*3-1:0]        atten_in,
  input  logic [CHANNELS-1:0]          mute_in,
  input  logic                         clear_in,
  output logic [CHANNELS-1:0]          underrun_out,
  output logic                         sample_tick_out,
  output logic                         pwm_out
);

  localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int SUM_W = SAMPLE_W + $clog2(CHANNELS);

  localparam logic [SAMPLE_W-1:0]     MID      = {1'b1, {(SAMPLE_W-1){1'b0}}};
  localparam logic [DIV_W-1:0]        DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
  localparam logic signed [SUM_W-1:0] SAT_MAX  = SUM_W'((2 ** (SAMPLE_W - 1)) - 1);
  localparam logic signed [SUM_W-1:0] SAT_MIN  = SUM_W'(-(2 ** (SAMPLE_W - 1)));

  // Sample-rate timer and per-channel holding registers
  logic [DIV_W-1:0]                   tick_cnt_q, tick_cnt_d;
  logic                               tick;
  logic [CHANNELS-1:0]                full_q, full_d;
  logic [CHANNELS-1:0][SAMPLE_W-1:0]  hold_q, hold_d;
  logic [CHANNELS-1:0]                underrun_q, underrun_d;
  logic [CHANNELS-1:0][SAMPLE_W-1:0]  sub_smp;
  logic [CHANNELS-1:0][SAMPLE_W-1:0]  sel_smp;

  // Mix pipeline
  logic [CHANNELS-1:0][SAMPLE_W-1:0]  s1_q, s1_d;
  logic                               s1_vld_q, s1_vld_d;
  logic signed [SUM_W-1:0]            mix_sum;
  logic signed [SUM_W-1:0]            mix_sat;
  logic [SAMPLE_W-1:0]                mix_duty;
  logic [SAMPLE_W-1:0]                duty_pending_q, duty_pending_d;

  // PWM generator
  logic [SAMPLE_W-1:0]                pwm_cnt_q, pwm_cnt_d;
  logic [SAMPLE_W-1:0]                duty_active_q, duty_active_d;
  logic                               pwm_wrap;
  logic                               pwm_q, pwm_d;

  // Tick is decoded straight from the counter so stage 1 can load on the
  // same edge that ends the tick cycle.
  assign tick            = enable_in && (tick_cnt_q == DIV_LAST);
  assign sample_tick_out = tick;
  assign ready_out       = ~full_q;
  assign underrun_out    = underrun_q;
  assign pwm_out         = pwm_q;

`ifdef AUDIO_PWM_HOLD_EN
  logic [CHANNELS-1:0][SAMPLE_W-1:0]  last_q, last_d;

  // Remember each channel's most recently consumed sample for underrun replay
  always_comb begin
    last_d = last_q;
    for (int c = 0; c < CHANNELS; c++) begin
      if (tick && full_q[c]) last_d[c] = hold_q[c];
    end
  end

  // Last-sample registers, reset to midscale so an early underrun is silent
  always_ff @(posedge clk_100mhz or negedge rst_n_in) begin
    if (!rst_n_in) last_q <= {CHANNELS{MID}};
    else           last_q <= last_d;
  end

  assign sub_smp = last_q;
`else
  assign sub_smp = {CHANNELS{MID}};
`endif

  // Sample selection: the held value if one is waiting, else the substitute
  always_comb begin
    sel_smp = sub_smp;
    for (int c = 0; c < CHANNELS; c++) begin
      if (full_q[c]) sel_smp[c] = hold_q[c];
    end
  end

  // Tick timer, handshake, and sticky underrun flags
  always_comb begin
    tick_cnt_d = tick_cnt_q;
    if (enable_in) begin
      if (tick_cnt_q == DIV_LAST) tick_cnt_d = '0;
      else                        tick_cnt_d = tick_cnt_q + 1'b1;
    end

    full_d     = full_q;
    hold_d     = hold_q;
    underrun_d = clear_in ? '0 : underrun_q;
    for (int c = 0; c < CHANNELS; c++) begin
      // Consumption and a new transfer never coincide: a transfer needs the
      // register empty, and only a full register is consumed.
      if (tick && full_q[c])  full_d[c] = 1'b0;
      if (tick && !full_q[c]) underrun_d[c] = 1'b1;
      if (valid_in[c] && !full_q[c]) begin
        full_d[c] = 1'b1;
        hold_d[c] = sample_in[c*SAMPLE_W +: SAMPLE_W];
      end
    end
  end

  // Stage 1: recentre to signed, attenuate by arithmetic shift, apply mute
  always_comb begin
    s1_d     = s1_q;
    s1_vld_d = enable_in ? tick : s1_vld_q;
    if (tick) begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (mute_in[c]) s1_d[c] = '0;
        else            s1_d[c] = $signed(sel_smp[c] ^ MID) >>> atten_in[c*3 +: 3];
      end
    end
  end

  // Stage 2: signed sum, saturate to the sample range, add midscale back
  always_comb begin
    mix_sum = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      mix_sum = mix_sum + SUM_W'($signed(s1_q[c]));
    end
    if (mix_sum > SAT_MAX)      mix_sat = SAT_MAX;
    else if (mix_sum < SAT_MIN) mix_sat = SAT_MIN;
    else                        mix_sat = mix_sum;
    // Adding midscale to a value in range is the same as flipping its MSB
    mix_duty       = mix_sat[SAMPLE_W-1:0] ^ MID;
    duty_pending_d = (enable_in && s1_vld_q) ? mix_duty : duty_pending_q;
  end

  // PWM counter; duty only changes at the wrap so no period is ever truncated
  always_comb begin
    pwm_wrap      = enable_in && (pwm_cnt_q == {SAMPLE_W{1'b1}});
    pwm_cnt_d     = enable_in ? pwm_cnt_q + 1'b1 : pwm_cnt_q;
    duty_active_d = pwm_wrap ? duty_pending_q : duty_active_q;
    pwm_d         = enable_in && (pwm_cnt_q < duty_active_q);
  end

  // State registers for timer, handshake, pipeline and PWM
  always_ff @(posedge clk_100mhz or negedge rst_n_in) begin
    if (!rst_n_in) begin
      tick_cnt_q     <= '0;
      full_q         <= '0;
      hold_q         <= '0;
      underrun_q     <= '0;
      s1_q           <= '0;
      s1_vld_q       <= 1'b0;
      duty_pending_q <= MID;
      pwm_cnt_q      <= '0;
      duty_active_q  <= MID;
      pwm_q          <= 1'b0;
    end else begin
      tick_cnt_q     <= tick_cnt_d;
      full_q         <= full_d;
      hold_q         <= hold_d;
      underrun_q     <= underrun_d;
      s1_q           <= s1_d;
      s1_vld_q       <= s1_vld_d;
      duty_pending_q <= duty_pending_d;
      pwm_cnt_q      <= pwm_cnt_d;
      duty_active_q  <= duty_active_d;
      pwm_q          <= pwm_d;
    end
  end

endmodule
